// File: rtl/ls_pkg.sv
// Shared types and constants for the load/store memory path.
package ls_pkg;

    // Access size select, using the load/store extender's encoding.
    typedef enum logic [2:0] {
        LS_W  = 3'd0,
        LS_H  = 3'd1,
        LS_B  = 3'd2,
        LS_HU = 3'd3,
        LS_BU = 3'd4
    } ls_sel_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } ls_state_e;

    // Access width after decoding the select.
    typedef enum logic [1:0] {
        SZ_W,
        SZ_H,
        SZ_B
    } ls_size_e;

    // Byte-enable patterns for lane 0; shifted up by the byte offset.
    localparam logic [3:0] BE_W = 4'b1111;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_B = 4'b0001;

    // Signed and unsigned variants share a width; unused codes fall back to word.
    function automatic ls_size_e sel_size(input logic [2:0] sel);
        case (sel)
            LS_H, LS_HU: return SZ_H;
            LS_B, LS_BU: return SZ_B;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Byte-lane alignment: enables, store data placement, load data
// right-justification and the misalignment flag for one access.
module ls_lane_align
    import ls_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [1:0]       offset,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] rdata,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata_aligned,
    output logic [WIDTH-1:0] rdata_aligned,
    output logic             misaligned
);

    logic [4:0] shamt;

    assign shamt = {offset, 3'b000};

    // Decode size into byte enables and alignment legality.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        be         = BE_W;
        misaligned = 1'b0;
        case (sel_size(sel))
            SZ_H: begin
                be         = BE_H << offset;
                misaligned = offset[0];
            end
            SZ_B: begin
                be         = BE_B << offset;
            end
            default: begin
                be         = BE_W;
                misaligned = |offset;
            end
        endcase
    end

    // Store data moves up into its lane; load data comes down to bit 0.
    // Sign/zero extension is left to the extender downstream.
    assign wdata_aligned = wdata << shamt;
    assign rdata_aligned = rdata >> shamt;

endmodule

// File: rtl/ls_mem_ctrl.sv
// Data-memory access controller: accepts one load/store from the MEM
// stage, runs the req/gnt/rvalid handshake and stalls until it completes.
module ls_mem_ctrl
    import ls_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [2:0]       req_sel,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    ls_state_e        state_q;
    logic             we_q;
    logic [1:0]       off_q;
    logic [CW-1:0]    cnt_q;

    logic [1:0]       al_off;
    logic [3:0]       al_be;
    logic [WIDTH-1:0] al_wdata;
    logic [WIDTH-1:0] al_rdata;
    logic             al_misaligned;

    // In IDLE the aligner sees the incoming request; afterwards it uses the
    // latched offset so the load shift matches the accepted address.
    assign al_off = (state_q == ST_IDLE) ? req_addr[1:0] : off_q;

    ls_lane_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .sel           (req_sel),
        .offset        (al_off),
        .wdata         (req_wdata),
        .rdata         (mem_rdata),
        .be            (al_be),
        .wdata_aligned (al_wdata),
        .rdata_aligned (al_rdata),
        .misaligned    (al_misaligned)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign stall     = ((state_q == ST_IDLE) && req_valid)
                     || (state_q == ST_REQ)
                     || (state_q == ST_WAIT);

    // Access FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            off_q      <= 2'b00;
            cnt_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q  <= req_we;
                        off_q <= req_addr[1:0];
                        if (al_misaligned) begin
                            state_q    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state_q   <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (we_q) begin
                            state_q    <= ST_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // Data arriving on the expiry cycle still wins.
                    if (mem_rvalid) begin
                        state_q    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= al_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Scoreboard bench for ls_mem_ctrl: the driver acts as MEM stage and
// memory, pushing each expected response; a monitor pops and compares.
module tb_ls_mem_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_sel;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    ls_mem_ctrl #(
        .WIDTH   (32),
        .TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_sel    (req_sel),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] rdata;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference rules: bytes per access and alignment legality.
    function automatic int nbytes(input logic [2:0] sel);
        case (sel)
            3'd1, 3'd3: return 2;
            3'd2, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    function automatic bit is_misal(input logic [2:0] sel, input logic [1:0] off);
        int n;
        n = nbytes(sel);
        return (n == 2 && off[0]) || (n == 4 && off != 2'b00);
    endfunction

    // Monitor: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn === 1'b1 && resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 want none (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("resp_cycle", cyc, mon_e.cyc);
                check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
                if (mon_e.chk) check("resp_rdata", resp_rdata, mon_e.rdata);
            end
        end
    end

    // One access; g = REQ cycles before grant, r = WAIT cycle of rvalid (r >= T: none).
    task automatic txn(input bit we, input logic [31:0] addr, input logic [2:0] sel,
                       input logic [31:0] wdata, input int g, input int r,
                       input logic [31:0] rd);
        int          a;
        int          n;
        int          bm;
        bit          mis;
        logic [1:0]  off;
        logic [3:0]  be_exp;
        logic [31:0] wd_exp;
        exp_t        e;
        off    = addr[1:0];
        n      = nbytes(sel);
        mis    = is_misal(sel, off);
        bm     = ((1 << n) - 1) << off;
        be_exp = bm[3:0];
        wd_exp = wdata << (8 * off);

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_sel   = sel;
        req_wdata = wdata;
        a = cyc + 1;
        e.chk = 1'b1;
        if (mis) begin
            e.cyc = a; e.err = 1'b1; e.rdata = '0; e.chk = 1'b0;
        end else if (we) begin
            e.cyc = a + 1 + g; e.err = 1'b0; e.rdata = last_rdata;
        end else if (r < T) begin
            e.cyc = a + 2 + g + r; e.err = 1'b0; e.rdata = rd >> (8 * off);
            last_rdata = e.rdata;
        end else begin
            e.cyc = a + 1 + g + T; e.err = 1'b1; e.rdata = '0;
            last_rdata = '0;
        end
        sb.push_back(e);
        #1;
        check("stall_idle_req", {31'b0, stall}, 32'd1);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);

        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (mis) begin
            #1;
            check("no_mem_req_misal", {31'b0, mem_req}, 32'd0);
            check("stall_resp", {31'b0, stall}, 32'd0);
        end else begin
            for (int i = 0; i <= g; i++) begin
                check("mem_req_held", {31'b0, mem_req}, 32'd1);
                check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check("mem_be", {28'b0, mem_be}, {28'b0, be_exp});
                check("mem_wdata", mem_wdata, wd_exp);
                check("mem_we", {31'b0, mem_we}, {31'b0, we});
                check("stall_req", {31'b0, stall}, 32'd1);
                mem_gnt    = (i == g);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                @(negedge clk);
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            check("mem_req_drop", {31'b0, mem_req}, 32'd0);
            if (we) check("stall_resp", {31'b0, stall}, 32'd0);
            if (!we) begin
                for (int j = 0; j < T && j <= r; j++) begin
                    check("stall_wait", {31'b0, stall}, 32'd1);
                    mem_rvalid = (j == r);
                    mem_rdata  = (j == r) ? rd : $urandom;
                    mem_gnt    = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                mem_gnt    = 1'b0;
            end
        end

        for (int k = 0; k < T + 10 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_missing: got no response want %0d pending consumed", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_sel    = '0;
        req_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_stall", {31'b0, stall}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed cases.
        txn(1'b1, 32'h0000_0100, 3'd0, 32'hBBBB_BBBB, 2, 0, 32'h0);
        txn(1'b1, 32'h0000_0103, 3'd2, 32'h0000_00C0, 0, 0, 32'h0);
        txn(1'b0, 32'h0000_0102, 3'd1, 32'h0, 0, 0, 32'h9BDF_C000);
        txn(1'b0, 32'h0000_0101, 3'd4, 32'h0, 1, 2, 32'h809B_DF40);
        txn(1'b1, 32'h0000_0100, 3'd3, 32'h0000_1234, 0, 0, 32'h0);
        txn(1'b0, 32'h0000_0102, 3'd0, 32'h0, 0, 0, 32'h0);
        txn(1'b0, 32'h0000_0101, 3'd1, 32'h0, 0, 0, 32'h0);
        txn(1'b0, 32'h0000_0200, 3'd0, 32'h0, 0, T, 32'hDEAD_BEEF);
        txn(1'b1, 32'h0000_0204, 3'd0, 32'h5555_AAAA, 1, 0, 32'h0);
        txn(1'b0, 32'h0000_0204, 3'd0, 32'h0, 0, T - 1, 32'h1234_5678);
        txn(1'b0, 32'h0000_0303, 3'd7, 32'h0, 0, 0, 32'h0);

        // Reset during WAIT aborts with no response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0400; req_sel = 3'd0;
        @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        last_rdata = '0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hFACE_CAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stale_rvalid_resp", {31'b0, resp_valid}, 32'd0);
        check("stale_rvalid_rdata", resp_rdata, 32'd0);
        txn(1'b0, 32'h0000_0408, 3'd0, 32'h0, 0, 0, 32'hA5A5_0F0F);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            txn(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, T + 1), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ls_mem_ctrl.md
Name: ls_mem_ctrl

Overview:
Data-memory access controller between the load/store extender and the data-memory bus. It takes load/store requests from the MEM stage, aligns store data to the byte lane and generates byte enables. It runs the request/grant/response handshake with memory, right-justifies read data into the extender's load input, and stalls the pipeline until the access completes. Misaligned accesses and memory timeouts are reported as errors.

Parameters:
WIDTH, 32, data and address width (only 32 supported)
TIMEOUT, 16, maximum cycles in WAIT before a read is aborted with error (>=2)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
req_valid  input  1  MEM-stage access request
req_ready  output  1  controller can accept a request (combinational: state==IDLE)
req_we  input  1  1=store, 0=load
req_addr  input  WIDTH  byte address
req_sel  input  3  size select, extender encoding: 0 word, 1 half signed, 2 byte signed, 3 half unsigned, 4 byte unsigned
req_wdata  input  WIDTH  store data, right-justified (extender store output)
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid: misaligned or timeout
resp_rdata  output  WIDTH  read word shifted right by addr[1:0]*8 (feeds extender load input)
stall  output  1  pipeline hold
mem_req  output  1  memory request, held until grant
mem_we  output  1  memory write
mem_addr  output  WIDTH  word address {req_addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  WIDTH  lane-aligned store data
mem_gnt  input  1  memory accepted request
mem_rvalid  input  1  read data valid
mem_rdata  input  WIDTH  read word

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all registered outputs 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_err, resp_rdata); timeout counter 0. A reset mid-access aborts it with no response.
- Size from req_sel: 0 -> 4 bytes; 1 or 3 -> 2 bytes; 2 or 4 -> 1 byte; 5-7 -> treated as word.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch we/addr/sel/wdata.
  - Misaligned -> RESP with resp_err=1; no memory access.
  - Otherwise -> REQ. Next cycle: mem_req=1; mem_be = 4'b1111, 4'b0011<<addr[1:0], or 4'b0001<<addr[1:0] by size; mem_wdata = wdata<<(addr[1:0]*8).
- REQ: hold mem_req and all mem_* stable until mem_gnt.
  - mem_gnt with store -> RESP (err=0).
  - mem_gnt with load -> WAIT, counter cleared.
  - mem_req drops the cycle after grant.
- WAIT: counter increments each cycle.
  - mem_rvalid -> capture resp_rdata = mem_rdata>>(addr[1:0]*8), -> RESP.
  - Counter reaches TIMEOUT-1 without rvalid -> RESP with resp_err=1, resp_rdata=0.
  - rvalid in the same cycle as expiry: data wins, err=0.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. resp_rdata holds until the next read response. Loads respond minimum 3 cycles after acceptance with a 1-cycle grant and immediate rvalid; stores respond in 2.
- stall = (IDLE & req_valid) | REQ | WAIT. stall is low in RESP so the pipeline advances with the result.
- A new req_valid is ignored outside IDLE.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.

Decomposition:
- Shared package ls_pkg: ls_sel_e enum (LS_W=0, LS_H=1, LS_B=2, LS_HU=3, LS_BU=4); state enum; byte-enable constants BE_W/BE_H/BE_B.
- One sub-module ls_lane_align (combinational): size/offset -> mem_be, store left shift, load right shift, misalign flag. Reusable by a future cache front-end.

Test Plan:
- Store word addr 0x100, wdata 0xBBBB_BBBB, gnt after 2 cycles -> mem_addr 0x100, be 4'b1111, wdata 0xBBBB_BBBB; stall high until RESP; resp_valid one cycle with err=0.
- Store byte sel=2 addr 0x103, wdata 0x0000_00C0 -> be 4'b1000, mem_wdata 0xC000_0000, mem_addr 0x100.
- Load half sel=1 addr 0x102, mem_rdata 0x9BDF_C000 -> resp_rdata 0x0000_9BDF. Load byte sel=4 addr 0x101, mem_rdata 0x809B_DF40 -> resp_rdata 0x0080_9BDF.
- Misaligned word addr 0x102 and half addr 0x101 -> no mem_req; resp_valid with resp_err=1 one cycle after acceptance.
- Load with no rvalid -> resp_err=1 exactly TIMEOUT cycles after entering WAIT. Repeat with rvalid on the last cycle -> err=0 and data returned.
- Assert rstn low during WAIT -> mem_req/resp_valid 0 immediately. After release, a fresh word load completes normally; a stale rvalid pulsed in IDLE is ignored.
